// File: rtl/execute_mul_sequencer.sv
// ---------------------------------------------------------------------------
// execute_mul_sequencer
//
// Multi-cycle controller for the LEGv8 MUL instruction in the execute stage.
// A MUL issued from ID/EX is accepted in IDLE. It is then computed by an
// iterative radix-2 shift-add loop, one multiplier bit per cycle. The pipeline
// is stalled for the whole loop. When the low WORD bits of the product are
// ready, done pulses for one cycle. Other opcodes are ignored and go through
// the single-cycle ALU path.
//
// Optional feature (compile-time macro MUL_EARLY_TERM_EN):
//   When it is defined, the loop also ends after any iteration that leaves the
//   shifted multiplier at zero. Results are the same; only the latency changes.
//
// Ports:
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous reset, active-low
//   start      in   1     ID/EX holds a valid instruction this cycle
//   opcode     in   11    instruction opcode from ID/EX
//   operand_a  in   WORD  multiplicand (read_data1)
//   operand_b  in   WORD  multiplier (read_data2)
//   flush      in   1     pipeline flush; aborts any MUL in progress
//   stall      out  1     hold PC, IF/ID and ID/EX (combinational)
//   busy       out  1     sequencer not in IDLE
//   done       out  1     one-cycle pulse; product valid from the next cycle
//   product    out  WORD  low WORD bits of operand_a*operand_b
// ---------------------------------------------------------------------------
module execute_mul_sequencer #(
  parameter int          WORD       = 64,
  parameter logic [10:0] MUL_OPCODE = 11'h4D8,
  parameter int          CNT_W      = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [10:0]     opcode,
  input  logic [WORD-1:0] operand_a,
  input  logic [WORD-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] product
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WORD-1:0]   r_a;
  logic [WORD-1:0]   r_b;
  logic [WORD-1:0]   r_acc;
  logic [WORD-1:0]   r_product;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_last_iter;
  logic [WORD-1:0]   w_b_shift;

  // Flush has priority over start, so a flushed MUL is never accepted.
  assign w_accept  = (r_state == S_IDLE) && start && (opcode == MUL_OPCODE) && !flush;
  assign w_b_shift = r_b >> 1;

  // End-of-loop detection: the counter reaches WORD on this iteration.
  // The early-term build also stops once no multiplier bits remain.
`ifdef MUL_EARLY_TERM_EN
  assign w_last_iter = (r_cnt == CNT_W'(WORD - 1)) || (w_b_shift == {WORD{1'b0}});
`else
  assign w_last_iter = (r_cnt == CNT_W'(WORD - 1));
`endif

  assign busy    = (r_state != S_IDLE);
  assign product = r_product;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and combinational outputs; flush suppresses stall and done at once
  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next = S_RUN;
          stall        = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (flush) begin
          w_state_next = S_IDLE;
        end else if (w_last_iter) begin
          w_state_next = S_DONE;
          stall        = 1'b1;
        end else begin
          w_state_next = S_RUN;
          stall        = 1'b1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        if (flush) begin
          done = 1'b0;
        end else begin
          done = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Shift-add datapath: load on accept, one multiplier bit per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= {WORD{1'b0}};
      r_b   <= {WORD{1'b0}};
      r_acc <= {WORD{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_a   <= operand_a;
      r_b   <= operand_b;
      r_acc <= {WORD{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == S_RUN) && !flush) begin
      // The carry out of the top bit is dropped: only the low half is kept.
      if (r_b[0]) begin
        r_acc <= r_acc + r_a;
      end else begin
        r_acc <= r_acc;
      end
      r_a   <= r_a << 1;
      r_b   <= w_b_shift;
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_a   <= r_a;
      r_b   <= r_b;
      r_acc <= r_acc;
      r_cnt <= r_cnt;
    end
  end

  // Result register: updated only by a DONE cycle that is not flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_product <= {WORD{1'b0}};
    end else if ((r_state == S_DONE) && !flush) begin
      r_product <= r_acc;
    end else begin
      r_product <= r_product;
    end
  end

endmodule

// File: tb/tb_execute_mul_sequencer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for execute_mul_sequencer.
// The driver issues instructions and pushes the expected product and done
// cycle into a queue. A monitor pops an entry on every done pulse and checks
// it. The reference result is plain a*b truncated to 64 bits. The reference
// latency comes from the bit position of the multiplier's highest set bit.
// ---------------------------------------------------------------------------
module tb_execute_mul_sequencer;

  localparam logic [10:0] MUL_OP = 11'h4D8;
  localparam logic [10:0] ADD_OP = 11'h458;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [10:0] opcode = 11'h000;
  logic [63:0] operand_a = 64'h0;
  logic [63:0] operand_b = 64'h0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [63:0] product;

  execute_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [63:0] last_prod = 64'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Number of RUN cycles the sequencer needs for multiplier b
  function automatic int model_lat(logic [63:0] b);
    int l;
`ifdef MUL_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < 64; i++) if (b[i]) l = i + 1;
`else
    l = 64;
`endif
    return l;
  endfunction

  // Monitor: check each done pulse against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending MUL");
      end else begin
        mon_e = q.pop_front();
        check("done_cycle", 64'(cyc), 64'(mon_e.acc_cyc + mon_e.lat + 1));
        check("stall_in_done", {63'h0, stall}, 64'h0);
        @(posedge clk);
        #1;
        check("product", product, mon_e.prod);
        last_prod = mon_e.prod;
      end
    end else if (rst_n && busy) begin
      check("product_held", product, last_prod);
    end
  end

  // Issue one MUL. If flush_k > 0, flush in RUN cycle flush_k (which may be the DONE cycle).
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input int flush_k);
    exp_t e;
    bit   ok;
    @(posedge clk); #1;
    start = 1'b1; opcode = MUL_OP; operand_a = a; operand_b = b; flush = 1'b0;
    e.prod = a * b; e.acc_cyc = cyc; e.lat = model_lat(b);
    q.push_back(e);
    #1 check("stall_accept", {63'h0, stall}, 64'h1);
    // Keep start high with new operands in RUN cycle 1: it must be ignored.
    @(posedge clk); #1;
    operand_a = {$urandom, $urandom}; operand_b = {$urandom, $urandom};
    #1 check("stall_run", {63'h0, stall}, 64'h1);
    if (flush_k > 0) begin
      for (int k = 2; k <= flush_k; k++) begin
        @(posedge clk); #1; start = 1'b0;
      end
      flush = 1'b1;
      #1;
      check("stall_flush", {63'h0, stall}, 64'h0);
      check("done_flush", {63'h0, done}, 64'h0);
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      if (q.size() > 0) void'(q.pop_back());
      check("busy_after_flush", {63'h0, busy}, 64'h0);
      check("stall_after_flush", {63'h0, stall}, 64'h0);
      check("product_after_flush", product, last_prod);
    end else begin
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk); #1; start = 1'b0;
        if (!busy) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout: got busy=1 expected idle within 100 cycles");
      end
    end
  endtask

  task automatic non_mul();
    @(posedge clk); #1;
    start = 1'b1; opcode = ADD_OP; operand_a = {$urandom, $urandom}; operand_b = 64'h5;
    #1 check("stall_nonmul", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_nonmul", {63'h0, busy}, 64'h0);
  endtask

  task automatic flush_with_start();
    @(posedge clk); #1;
    start = 1'b1; opcode = MUL_OP; operand_a = 64'h9; operand_b = 64'h9; flush = 1'b1;
    #1 check("stall_flush_start", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("busy_flush_start", {63'h0, busy}, 64'h0);
  endtask

  // Reset asserted in RUN cycle k
  task automatic reset_mid(input int k);
    @(posedge clk); #1;
    start = 1'b1; opcode = MUL_OP; operand_a = 64'h1234; operand_b = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (k - 1) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    last_prod = 64'h0;
    q.delete();
    #1;
    check("rst_product", product, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_stall", {63'h0, stall}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] b;
    int          fk;
    repeat (2) @(posedge clk);
    #1;
    check("reset_product", product, 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_stall", {63'h0, stall}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    rst_n = 1'b1;

    run_mul(64'd3, 64'd5, 0);
    run_mul(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 0);
    run_mul(64'h8000_0000_0000_0000, 64'd2, 0);
    run_mul(64'hDEAD_BEEF_0000_1111, 64'd77, 10);
    non_mul();
    flush_with_start();
    run_mul(64'd11, 64'd0, 0);
    reset_mid(20);
    run_mul(64'd7, 64'd6, 0);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);

    for (int t = 0; t < 20; t++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = 64'h0;
        1:       b = 64'($urandom_range(0, 255));
        2:       b = {$urandom, $urandom};
        default: b = 64'h1 << $urandom_range(0, 63);
      endcase
      fk = ($urandom_range(0, 4) == 0) ? $urandom_range(1, model_lat(b) + 1) : 0;
      run_mul(a, b, fk);
      if ($urandom_range(0, 3) == 0) non_mul();
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
